// File: rtl/gnrl_elastic_pipe_pkg.sv
// ---------------------------------------------------------------------------
// gnrl_elastic_pipe_pkg
//   Shared helpers for the elastic pipe slice:
//     - clog2(): constant ceil(log2(n)), with clog2(1) = 0
//     - `GNRL_EP_PW(depth): pointer width, max(1, clog2(depth))
//     - `GNRL_EP_CW(depth): occupancy counter width, clog2(depth+1)
//     - GNRL_EP_XCHECK: define it in the simulation build to enable
//       X-checks on the handshake inputs.
// ---------------------------------------------------------------------------
`ifndef GNRL_ELASTIC_PIPE_PKG_SV
`define GNRL_ELASTIC_PIPE_PKG_SV

`define GNRL_EP_PW(depth) (((depth) > 1) ? gnrl_elastic_pipe_pkg::clog2(depth) : 1)
`define GNRL_EP_CW(depth) (gnrl_elastic_pipe_pkg::clog2((depth) + 1))

package gnrl_elastic_pipe_pkg;

    // Smallest r such that 2**r >= n; bounded loop keeps it a constant function.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/gnrl_elastic_pipe_dffrl.sv
// ---------------------------------------------------------------------------
// gnrl_dffrl
//   DW-wide load-enable flip-flop with optional synchronous active-high reset.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   synchronous active-high reset (used only when RST_EN != 0)
//     lden  in   load enable; register holds its value while low
//     dnxt  in   DW  next value
//     qout  out  DW  registered value
//   Parameters:
//     DW     data width
//     RST_EN 1 = clear to 0 on rst, 0 = no reset (datapath register)
// ---------------------------------------------------------------------------
module gnrl_dffrl #(
    parameter int DW     = 32,
    parameter int RST_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    generate
        if (RST_EN != 0) begin : g_rst
            // Reset has priority over a coincident load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    qout <= '0;
                end else if (lden) begin
                    qout <= dnxt;
                end
            end
        end else begin : g_norst
            logic unused_rst;
            assign unused_rst = rst;

            // No reset on the datapath flavour; the register only ever moves on lden.
            always_ff @(posedge clk) begin
                if (lden) begin
                    qout <= dnxt;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/gnrl_elastic_pipe.sv
// ---------------------------------------------------------------------------
// gnrl_elastic_pipe
//   Elastic register stage: DEPTH-entry circular buffer of DW-bit words behind
//   valid/ready handshakes on both sides. Output data always comes from a
//   register, so there is no combinational i_dat -> o_dat path.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset (control state; data if DP_RST)
//     i_vld  in   upstream valid
//     i_rdy  out  block can accept i_dat this cycle
//     i_dat  in   DW  upstream data
//     o_vld  out  head entry valid
//     o_rdy  in   downstream accepts head entry
//     o_dat  out  DW  head entry data
//     cnt    out  CW  occupied entries, CW = clog2(DEPTH+1)
//     full   out  cnt == DEPTH
//     empty  out  cnt == 0
//   Parameters:
//     DW, DEPTH, CUT_READY (1: i_rdy = !full, 0: i_rdy = !full | o_rdy),
//     DP_RST (1: data entries clear on rst)
// ---------------------------------------------------------------------------
module gnrl_elastic_pipe
    import gnrl_elastic_pipe_pkg::*;
#(
    parameter int DW        = 32,
    parameter int DEPTH     = 2,
    parameter int CUT_READY = 1,
    parameter int DP_RST    = 0,
    localparam int CW       = `GNRL_EP_CW(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    localparam int            PW       = `GNRL_EP_PW(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic          push;
    logic          pop;
    logic          wr_en;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr_nxt;
    logic [PW-1:0] wptr_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_lden;
    logic [DW-1:0] entry [DEPTH];

    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
    assign o_vld = !empty;

    // With CUT_READY=0 a full buffer still accepts when the head is leaving,
    // reusing the slot being popped in the same cycle.
    generate
        if (CUT_READY != 0) begin : g_cut
            assign i_rdy = !full;
        end else begin : g_pass
            assign i_rdy = !full | o_rdy;
        end
    endgenerate

    assign push  = i_vld & i_rdy;
    assign pop   = o_vld & o_rdy;
    assign wr_en = push & !rst;

    // Pointers wrap at DEPTH-1 rather than at a power of two, so odd depths
    // never index past the last entry.
    always_comb begin
        rptr_nxt = (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
        wptr_nxt = (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
    end

    // Count only moves when exactly one of push/pop happens.
    always_comb begin
        cnt_lden = push ^ pop;
        cnt_nxt  = push ? cnt + CW'(1) : cnt - CW'(1);
    end

    gnrl_dffrl #(.DW(PW), .RST_EN(1)) u_rptr (
        .clk  (clk),
        .rst  (rst),
        .lden (pop),
        .dnxt (rptr_nxt),
        .qout (rptr)
    );

    gnrl_dffrl #(.DW(PW), .RST_EN(1)) u_wptr (
        .clk  (clk),
        .rst  (rst),
        .lden (push),
        .dnxt (wptr_nxt),
        .qout (wptr)
    );

    gnrl_dffrl #(.DW(CW), .RST_EN(1)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .lden (cnt_lden),
        .dnxt (cnt_nxt),
        .qout (cnt)
    );

    // Each entry loads only when the write pointer selects it, so idle
    // entries never toggle.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            gnrl_dffrl #(.DW(DW), .RST_EN(DP_RST)) u_entry (
                .clk  (clk),
                .rst  (rst),
                .lden (wr_en && (wptr == PW'(i))),
                .dnxt (i_dat),
                .qout (entry[i])
            );
        end

        if (DEPTH == 1) begin : g_head1
            assign o_dat = entry[0];
        end else begin : g_headn
            assign o_dat = entry[rptr];
        end
    endgenerate

`ifndef SYNTHESIS
    ap_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop));
    ap_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop && empty));
`ifdef GNRL_EP_XCHECK
    ap_xcheck_i_vld : assert property (@(posedge clk) disable iff (rst)
        !$isunknown(i_vld));
    ap_xcheck_o_rdy : assert property (@(posedge clk) disable iff (rst)
        !$isunknown(o_rdy));
`endif
`endif

endmodule

// File: tb/tb_gnrl_elastic_pipe.sv
// ---------------------------------------------------------------------------
// tb_gnrl_elastic_pipe
//   Five instances: 0 = DEPTH2/CUT1/DP_RST1, 1 = DEPTH2/CUT0, 2 = DEPTH3/CUT1/
//   DP_RST1, 3 = DEPTH1/CUT1, 4 = DEPTH1/CUT0. Each is driven independently.
// ---------------------------------------------------------------------------
module tb_gnrl_elastic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]       rst_v;
    logic [4:0]       vld_v;
    logic [4:0]       ordy_v;
    logic [4:0]       irdy_v;
    logic [4:0]       ovld_v;
    logic [4:0]       full_v;
    logic [4:0]       empty_v;
    logic [4:0][31:0] idat_v;
    logic [4:0][31:0] odat_v;
    logic [1:0]       cnt_a;
    logic [1:0]       cnt_b;
    logic [1:0]       cnt_c;
    logic             cnt_d;
    logic             cnt_e;

    int checks = 0;
    int passes = 0;

    gnrl_elastic_pipe #(.DW(32), .DEPTH(2), .CUT_READY(1), .DP_RST(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .i_vld(vld_v[0]), .i_rdy(irdy_v[0]),
        .i_dat(idat_v[0]), .o_vld(ovld_v[0]), .o_rdy(ordy_v[0]), .o_dat(odat_v[0]),
        .cnt(cnt_a), .full(full_v[0]), .empty(empty_v[0])
    );

    gnrl_elastic_pipe #(.DW(32), .DEPTH(2), .CUT_READY(0), .DP_RST(0)) u_b (
        .clk(clk), .rst(rst_v[1]), .i_vld(vld_v[1]), .i_rdy(irdy_v[1]),
        .i_dat(idat_v[1]), .o_vld(ovld_v[1]), .o_rdy(ordy_v[1]), .o_dat(odat_v[1]),
        .cnt(cnt_b), .full(full_v[1]), .empty(empty_v[1])
    );

    gnrl_elastic_pipe #(.DW(32), .DEPTH(3), .CUT_READY(1), .DP_RST(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .i_vld(vld_v[2]), .i_rdy(irdy_v[2]),
        .i_dat(idat_v[2]), .o_vld(ovld_v[2]), .o_rdy(ordy_v[2]), .o_dat(odat_v[2]),
        .cnt(cnt_c), .full(full_v[2]), .empty(empty_v[2])
    );

    gnrl_elastic_pipe #(.DW(32), .DEPTH(1), .CUT_READY(1), .DP_RST(0)) u_d (
        .clk(clk), .rst(rst_v[3]), .i_vld(vld_v[3]), .i_rdy(irdy_v[3]),
        .i_dat(idat_v[3]), .o_vld(ovld_v[3]), .o_rdy(ordy_v[3]), .o_dat(odat_v[3]),
        .cnt(cnt_d), .full(full_v[3]), .empty(empty_v[3])
    );

    gnrl_elastic_pipe #(.DW(32), .DEPTH(1), .CUT_READY(0), .DP_RST(0)) u_e (
        .clk(clk), .rst(rst_v[4]), .i_vld(vld_v[4]), .i_rdy(irdy_v[4]),
        .i_dat(idat_v[4]), .o_vld(ovld_v[4]), .o_rdy(ordy_v[4]), .o_dat(odat_v[4]),
        .cnt(cnt_e), .full(full_v[4]), .empty(empty_v[4])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one instance's inputs, then let combinational outputs settle.
    task automatic applyStimulus(input int idx, input logic r, input logic v,
                                 input logic [31:0] d, input logic o);
        rst_v[idx]  = r;
        vld_v[idx]  = v;
        idat_v[idx] = d;
        ordy_v[idx] = o;
        #1;
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int   q[$];
    int   nextIn;
    int   outCount;
    int   cycles;
    int   popsD;
    int   popsE;
    logic [31:0] lastD;
    logic [31:0] lastE;
    logic tv;
    logic to;
    logic expPush;
    logic expPop;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_v  = '1;
        vld_v  = '0;
        ordy_v = '0;
        idat_v = '0;
        tick();
        tick();
        rst_v = '0;
        #1;

        // Reset state on every instance.
        checkOutput("rst_ovld_all", 32'(ovld_v), 32'h0);
        checkOutput("rst_irdy_all", 32'(irdy_v), 32'h1F);
        checkOutput("rst_empty_all", 32'(empty_v), 32'h1F);
        checkOutput("rst_full_all", 32'(full_v), 32'h0);
        checkOutput("rst_cnt_a", 32'(cnt_a), 32'h0);
        checkOutput("rst_cnt_b", 32'(cnt_b), 32'h0);
        checkOutput("rst_cnt_c", 32'(cnt_c), 32'h0);
        checkOutput("rst_cnt_d", 32'(cnt_d), 32'h0);
        checkOutput("rst_cnt_e", 32'(cnt_e), 32'h0);
        checkOutput("rst_odat_a", odat_v[0], 32'h0);
        checkOutput("rst_odat_c", odat_v[2], 32'h0);

        // Fill DEPTH=2 CUT=1, back-pressure, then drain in order.
        applyStimulus(0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
        tick();
        checkOutput("a_cnt1", 32'(cnt_a), 32'd1);
        checkOutput("a_ovld1", 32'(ovld_v[0]), 32'd1);
        checkOutput("a_lat1", odat_v[0], 32'hA5A5_0001);
        applyStimulus(0, 1'b0, 1'b1, 32'hA5A5_0002, 1'b0);
        tick();
        checkOutput("a_cnt2", 32'(cnt_a), 32'd2);
        checkOutput("a_full", 32'(full_v[0]), 32'd1);
        checkOutput("a_irdy_full", 32'(irdy_v[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'hA5A5_0003, 1'b0);
        tick();
        checkOutput("a_cnt_hold", 32'(cnt_a), 32'd2);
        checkOutput("a_head_hold", odat_v[0], 32'hA5A5_0001);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("a_pop0", odat_v[0], 32'hA5A5_0001);
        tick();
        checkOutput("a_pop1", odat_v[0], 32'hA5A5_0002);
        checkOutput("a_cnt_pop", 32'(cnt_a), 32'd1);
        tick();
        checkOutput("a_empty", 32'(empty_v[0]), 32'd1);
        checkOutput("a_ovld_end", 32'(ovld_v[0]), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 1'b0);

        // CUT=0: full with push and pop together keeps streaming.
        applyStimulus(1, 1'b0, 1'b1, 32'd100, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 1'b1, 32'd101, 1'b0);
        tick();
        checkOutput("b_cnt_full", 32'(cnt_b), 32'd2);
        checkOutput("b_irdy_blocked", 32'(irdy_v[1]), 32'd0);
        applyStimulus(1, 1'b0, 1'b1, 32'd102, 1'b1);
        checkOutput("b_irdy_pass", 32'(irdy_v[1]), 32'd1);
        tick();
        checkOutput("b_cnt_same", 32'(cnt_b), 32'd2);
        checkOutput("b_head_next", odat_v[1], 32'd101);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 1'b0, 1'b1, 32'(103 + i), 1'b1);
            checkOutput("b_stream_dat", odat_v[1], 32'(101 + i));
            checkOutput("b_stream_cnt", 32'(cnt_b), 32'd2);
            tick();
        end
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("b_drain0", odat_v[1], 32'd201);
        tick();
        checkOutput("b_drain1", odat_v[1], 32'd202);
        tick();
        checkOutput("b_drain_empty", 32'(empty_v[1]), 32'd1);

        // Reset with cnt=2 and push+pop asserted on the same edge.
        applyStimulus(1, 1'b0, 1'b1, 32'd11, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 1'b1, 32'd22, 1'b0);
        tick();
        checkOutput("b_pre_rst_cnt", 32'(cnt_b), 32'd2);
        applyStimulus(1, 1'b1, 1'b1, 32'd33, 1'b1);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("b_rst_cnt", 32'(cnt_b), 32'd0);
        checkOutput("b_rst_ovld", 32'(ovld_v[1]), 32'd0);
        checkOutput("b_rst_irdy", 32'(irdy_v[1]), 32'd1);
        tick();
        tick();
        checkOutput("b_rst_no_ghost", 32'(ovld_v[1]), 32'd0);
        applyStimulus(1, 1'b0, 1'b1, 32'd44, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("b_post_rst_dat", odat_v[1], 32'd44);
        checkOutput("b_post_rst_cnt", 32'(cnt_b), 32'd1);

        // DEPTH=3: 10 words with random downstream stalls, queue model.
        nextIn   = 0;
        outCount = 0;
        cycles   = 0;
        while (outCount < 10 && cycles < 300) begin
            tv = (nextIn < 10);
            to = ($urandom_range(0, 1) == 1);
            applyStimulus(2, 1'b0, tv, 32'(nextIn), to);
            checkOutput("c_cnt", 32'(cnt_c), 32'(q.size()));
            checkOutput("c_irdy", 32'(irdy_v[2]), 32'(q.size() < 3));
            checkOutput("c_ovld", 32'(ovld_v[2]), 32'(q.size() > 0));
            expPush = tv && (q.size() < 3);
            expPop  = to && (q.size() > 0);
            if (expPop) begin
                checkOutput("c_order", odat_v[2], 32'(outCount));
                void'(q.pop_front());
                outCount++;
            end
            if (expPush) begin
                q.push_back(nextIn);
                nextIn++;
            end
            tick();
            cycles++;
        end
        applyStimulus(2, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("c_all_out", 32'(outCount), 32'd10);
        checkOutput("c_final_empty", 32'(empty_v[2]), 32'd1);

        // DEPTH=1 throughput in both ready modes.
        popsD = 0;
        popsE = 0;
        lastD = '0;
        lastE = '0;
        applyStimulus(3, 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(4, 1'b0, 1'b1, 32'h0, 1'b1);
        for (int t = 0; t < 10; t++) begin
            idat_v[3] = 32'(t);
            idat_v[4] = 32'(t);
            #1;
            if (t == 1) begin
                checkOutput("d_irdy_occupied", 32'(irdy_v[3]), 32'd0);
                checkOutput("e_irdy_occupied", 32'(irdy_v[4]), 32'd1);
            end
            if (ovld_v[3]) begin
                popsD++;
                lastD = odat_v[3];
            end
            if (ovld_v[4]) begin
                popsE++;
                lastE = odat_v[4];
            end
            tick();
        end
        applyStimulus(3, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(4, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("d_half_rate", 32'(popsD), 32'd5);
        checkOutput("e_full_rate", 32'(popsE), 32'd9);
        checkOutput("d_last", lastD, 32'd8);
        checkOutput("e_last", lastE, 32'd8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gnrl_elastic_pipe.md
Name: gnrl_elastic_pipe

Overview:
- Parametrised elastic register stage, the next generation of the general load-enable DFF.
- Holds DEPTH entries of DW bits behind a valid/ready handshake on both sides.
- Entry registers are optionally resettable.
- Selectable ready-cut mode breaks the combinational ready path between pipeline stages.
- Used between LSU/cache and core pipeline boundaries wherever a plain load-enable register cannot absorb back-pressure.

Parameters:
- DW, 32: data width in bits, >=1.
- DEPTH, 2: number of storage entries, >=1.
- CUT_READY, 1: 1 = i_rdy depends only on registered state; 0 = i_rdy may also follow o_rdy combinationally when full.
- DP_RST, 0: 1 = data entries clear to 0 on rst; 0 = data entries have no reset (only control state resets).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- i_vld  input  1  upstream data valid.
- i_rdy  output  1  block can accept i_dat this cycle.
- i_dat  input  DW  upstream data.
- o_vld  output  1  head entry valid.
- o_rdy  input  1  downstream accepts head entry.
- o_dat  output  DW  head entry data.
- cnt  output  CW  occupied entries, CW = clog2(DEPTH+1).
- full  output  1  cnt == DEPTH.
- empty  output  1  cnt == 0.

Behaviour:
- Handshakes:
  - push = i_vld & i_rdy; pop = o_vld & o_rdy.
  - Transfers occur only on rising clk edges.
- Storage:
  - Circular buffer with rptr/wptr, each PW = max(1, clog2(DEPTH)) bits.
  - Each pointer wraps from DEPTH-1 to 0 (not a power-of-two wrap when DEPTH is not a power of 2).
- Outputs:
  - o_vld = !empty; o_dat = entry[rptr].
  - o_dat is registered data, no combinational input-to-output path.
  - Latency i_dat -> o_dat is 1 cycle when the block is empty.
  - o_dat is don't-care while o_vld=0, but must not be X when DP_RST=1.
- i_rdy:
  - CUT_READY=1: i_rdy = !full.
  - CUT_READY=0: i_rdy = !full | o_rdy.
- Simultaneous push and pop:
  - cnt unchanged; both pointers advance.
  - When full with CUT_READY=0, the pop slot is reused in the same cycle.
- Push only: entry[wptr] <= i_dat, wptr advances, cnt+1.
- Pop only: rptr advances, cnt-1.
- Never allowed: push when full with pop=0, or pop when empty. These cannot occur through the ready/valid logic; a simulation assertion flags internal violation.
- Load-enable: entry registers load only on push to their index. Unselected entries hold their value and must not toggle.
- Reset:
  - rst=1 at a clock edge: rptr=0, wptr=0, cnt=0.
  - Resulting outputs: o_vld=0, empty=1, full=0.
  - i_rdy=1 in both modes (CUT_READY=0 still yields 1 since !full).
  - Data entries cleared to 0 only if DP_RST=1.
  - Reset mid-operation discards all held entries.
  - A push or pop coincident with rst is ignored; reset wins.
- X-check: in simulation builds, i_vld and o_rdy are checked for X while rst=0.
- DEPTH=1, CUT_READY=1: the block is a half-bandwidth register (i_rdy=0 while occupied).
- DEPTH=1, CUT_READY=0: full throughput when downstream is ready.

Decomposition:
- Shared package holds:
  - a clog2 function;
  - PW/CW width derivation macros;
  - shared X-check enable define names.
- One natural sub-module: gnrl_dffrl (DW-wide load-enable DFF with synchronous active-high reset, parameter RST_EN).
  - Instantiated DEPTH times for entries with RST_EN=DP_RST.
  - Reused for the pointer and count registers with RST_EN=1.

Test Plan:
- Reset then idle, DEPTH=2, CUT_READY=1 -> o_vld=0, i_rdy=1, cnt=0, empty=1, full=0; with DP_RST=1 o_dat=0.
- Push 0xA5A5_0001, 0xA5A5_0002 with o_rdy=0 -> cnt=2, full=1, i_rdy=0; third i_vld held high is not accepted. o_rdy=1 then pops 0x..01 then 0x..02 in order; empty after 2 cycles.
- CUT_READY=0, full, i_vld=1 and o_rdy=1 together -> i_rdy=1, cnt stays 2; the new word appears after the remaining head word; no loss or duplication over 100 back-to-back transfers.
- DEPTH=3 pointer wrap: stream 10 sequential words with random o_rdy stalls -> output sequence 0..9 exact; rptr/wptr wrap 2->0; cnt never exceeds 3.
- Mid-stream reset with cnt=2 and push+pop asserted at the same edge -> next cycle cnt=0, o_vld=0; the pushed word never emerges.
- DEPTH=1, CUT_READY=1, i_vld and o_rdy held high -> one transfer every 2 cycles; with CUT_READY=0 -> one transfer every cycle.
